// File: rtl/control_sequencer_if.sv
// Handshake bundle between the control sequencer and the datapath/select-encode stage.
// The master side is the sequencer; the slave side is the datapath that obeys the strobes.
interface control_sequencer_if;
    logic [31:0] ir;
    logic        con_ff;
    logic        mem_ready;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        Cout, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zlowout, CONin;
    logic        Read, Write;
    logic [3:0]  alu_op;
    logic        run;
    logic        err;

    modport master (
        input  ir, con_ff, mem_ready,
        output Gra, Grb, Grc, Rin, Rout, BAout,
        output Cout, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
        output Yin, Zin, Zlowout, CONin, Read, Write, alu_op, run, err
    );

    modport slave (
        output ir, con_ff, mem_ready,
        input  Gra, Grb, Grc, Rin, Rout, BAout,
        input  Cout, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
        input  Yin, Zin, Zlowout, CONin, Read, Write, alu_op, run, err
    );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle control unit: fetch T0-T2, execute T3-T7, with bounded memory wait states.
// Strobes are a combinational decode of the registered step; reset forces them low at once.
module control_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input logic                 clock,
    input logic                 reset_n,
    control_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        T0, T1, T2, T3, T4, T5, T6, T7, S_HALT, S_ERR
    } state_e;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        first_q;
    logic [4:0]  op_q;
    logic        run_q, err_q;

    logic [4:0]  op;
    logic        in_wait;
    logic        tmo;
    logic        is_r, is_i, is_mem;
    logic        unused_ir;

    assign unused_ir = ^bus.ir[26:0];

    // The opcode is taken live in T3 and held for the rest of the instruction.
    assign op     = (state_q == T3) ? bus.ir[31:27] : op_q;
    assign is_r   = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    assign is_i   = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
    assign is_mem = (op == OP_LD) || (op == OP_ST);

    assign in_wait = (state_q == T1) ||
                     ((state_q == T6) && (op == OP_LD)) ||
                     ((state_q == T7) && (op == OP_ST));

    // Fires on the last tolerated idle cycle, so a ready in that cycle never collides.
    assign tmo = (MEM_TIMEOUT != 0) && !bus.mem_ready &&
                 ((cnt_q + 32'd1) >= MEM_TIMEOUT);

    function automatic logic [3:0] alu_of(input logic [4:0] o);
        case (o)
            OP_SUB:          return 4'd1;
            OP_AND, OP_ANDI: return 4'd2;
            OP_OR,  OP_ORI:  return 4'd3;
            default:         return 4'd0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            T0: state_d = T1;
            T1: begin
                if (bus.mem_ready) state_d = T2;
                else if (tmo)      state_d = S_ERR;
            end
            T2: state_d = T3;
            T3: begin
                if (op == OP_NOP)                      state_d = T0;
                else if (op == OP_HALT)                state_d = S_HALT;
                else if (is_r || is_i || is_mem ||
                         op == OP_LDI || op == OP_BR)  state_d = T4;
                else                                   state_d = S_ERR;
            end
            T4: state_d = T5;
            T5: state_d = (is_mem || op == OP_BR) ? T6 : T0;
            T6: begin
                if (op == OP_LD) begin
                    if (bus.mem_ready) state_d = T7;
                    else if (tmo)      state_d = S_ERR;
                end else if (op == OP_ST) begin
                    state_d = T7;
                end else begin
                    state_d = T0;
                end
            end
            T7: begin
                if (op == OP_ST) begin
                    if (bus.mem_ready) state_d = T0;
                    else if (tmo)      state_d = S_ERR;
                end else begin
                    state_d = T0;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        if (state_d != state_q)
            cnt_d = '0;
        else if (in_wait && !bus.mem_ready && (cnt_q != '1))
            cnt_d = cnt_q + 32'd1;
        else
            cnt_d = cnt_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= T0;
            cnt_q   <= '0;
            first_q <= 1'b0;
            op_q    <= 5'd0;
            run_q   <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= (state_d != state_q);
            if (state_q == T3) op_q <= bus.ir[31:27];
            run_q   <= !((state_d == S_HALT) || (state_d == S_ERR));
            err_q   <= err_q || (state_d == S_ERR);
        end
    end

    assign bus.run = run_q;
    assign bus.err = err_q;

    always_comb begin
        bus.Gra = 1'b0;  bus.Grb = 1'b0;  bus.Grc = 1'b0;
        bus.Rin = 1'b0;  bus.Rout = 1'b0; bus.BAout = 1'b0;
        bus.Cout = 1'b0; bus.PCout = 1'b0; bus.PCin = 1'b0; bus.IncPC = 1'b0;
        bus.MARin = 1'b0; bus.MDRin = 1'b0; bus.MDRout = 1'b0; bus.IRin = 1'b0;
        bus.Yin = 1'b0;  bus.Zin = 1'b0;  bus.Zlowout = 1'b0; bus.CONin = 1'b0;
        bus.Read = 1'b0; bus.Write = 1'b0;
        bus.alu_op = 4'd0;
        if (reset_n) begin
            case (state_q)
                T0: begin
                    bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
                end
                T1: begin
                    bus.Zlowout = first_q;
                    bus.PCin    = first_q;
                    bus.Read    = 1'b1;
                    bus.MDRin   = bus.mem_ready;
                end
                T2: begin
                    bus.MDRout = 1'b1; bus.IRin = 1'b1;
                end
                T3: begin
                    if (is_mem || op == OP_LDI) begin
                        bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
                    end else if (is_r || is_i) begin
                        bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
                    end else if (op == OP_BR) begin
                        bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1;
                    end
                end
                T4: begin
                    if (is_r) begin
                        bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1;
                        bus.alu_op = alu_of(op);
                    end else if (op == OP_BR) begin
                        bus.PCout = 1'b1; bus.Yin = 1'b1;
                    end else begin
                        bus.Cout = 1'b1; bus.Zin = 1'b1;
                        bus.alu_op = alu_of(op);
                    end
                end
                T5: begin
                    if (is_mem) begin
                        bus.Zlowout = 1'b1; bus.MARin = 1'b1;
                    end else if (op == OP_BR) begin
                        bus.Cout = 1'b1; bus.Zin = 1'b1;
                    end else begin
                        bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                    end
                end
                T6: begin
                    if (op == OP_LD) begin
                        bus.Read  = 1'b1;
                        bus.MDRin = bus.mem_ready;
                    end else if (op == OP_ST) begin
                        bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
                    end else begin
                        bus.Zlowout = bus.con_ff;
                        bus.PCin    = bus.con_ff;
                    end
                end
                T7: begin
                    if (op == OP_ST) begin
                        bus.Write = 1'b1;
                    end else begin
                        bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
